condlogic_it: RTL and testbench

- Parametrised successor to the multicycle ARM condition unit.
- Holds NZCV, evaluates the 4-bit condition field, and gates PC, register and memory writes.
- Adds a Thumb-2-style IT (If-Then) sequencer that predicates up to MAX_IT following instructions.
- Adds a selectable flag-write timing mode: execute state or ALUWB state.
- Sits between the main controller FSM and the datapath enables.

---
 rtl/condlogic_it.sv | 120 ++++++++++++
 tb/tb_condlogic_it.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_it.sv
// condlogic_it: ARM condition unit with NZCV, write gating, IT-block sequencer and selectable flag-write timing
module condlogic_it #(
  parameter int MAX_IT = 4,
  parameter bit FLAG_WB_DELAY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       InstrDone,
  input  logic       ITStart,
  input  logic [3:0] ITCond,
  input  logic [2:0] ITLen,
  input  logic [3:0] ITThen,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       ITActive,
  output logic [1:0] ITSlot
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic [1:0] slot, slot_nx;
  logic [3:0] it_cond, it_then, ec;
  logic [2:0] it_len, len_c;
  logic       load, inv, cond_ex, cond_exq;
  logic [1:0] fw, fw_q, fw_en;
  logic       n, z, c, v;
  assign {n, z, c, v} = Flags;
  assign len_c = (ITLen > 3'(MAX_IT)) ? 3'(MAX_IT) : ITLen;
  // slot 0 always uses the base condition; AL/NV-class conditions are never inverted
  assign inv = (state == ACTIVE) && !(it_then[slot] || slot == 2'd0) && (it_cond[3:1] != 3'b111);
  assign ec  = (state == ACTIVE) ? {it_cond[3:1], it_cond[0] ^ inv} : Cond;
  always_comb begin
    cond_ex = 1'b0;
    case (ec)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  assign fw    = FlagW & {2{cond_ex}};
  assign fw_en = FLAG_WB_DELAY ? fw_q : fw;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags    <= 4'b0;
      cond_exq <= 1'b0;
      fw_q     <= 2'b0;
    end else begin
      cond_exq <= cond_ex;
      fw_q     <= fw;
      if (fw_en[1]) Flags[3:2] <= ALUFlags[3:2];
      if (fw_en[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end
  assign RegWrite = RegW && cond_exq && !NoWrite;
  assign MemWrite = MemW && cond_exq;
  assign PCWrite  = NextPC || (PCS && cond_exq);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      slot    <= 2'd0;
      it_cond <= 4'b0;
      it_then <= 4'b0;
      it_len  <= 3'd0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      if (load) begin
        it_cond <= ITCond;
        it_then <= ITThen;
        it_len  <= len_c;
      end
    end
  end
  // an InstrDone alongside ITStart belongs to the IT instruction, so IDLE ignores it
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    load     = 1'b0;
    if (state == IDLE) begin
      if (ITStart && ITLen != 3'd0) begin
        state_nx = ACTIVE;
        slot_nx  = 2'd0;
        load     = 1'b1;
      end
    end else if (InstrDone) begin
      if ((PCS && cond_exq) || ({1'b0, slot} == it_len - 3'd1)) begin
        state_nx = IDLE;
        slot_nx  = 2'd0;
      end else begin
        slot_nx = slot + 2'd1;
      end
    end
  end
  always_comb begin
    ITActive = (state == ACTIVE);
    ITSlot   = slot;
  end
endmodule

// File: tb/tb_condlogic_it.sv
// tb_condlogic_it: directed scoreboard bench for condlogic_it (immediate-flag and delayed-flag/MAX_IT=2 instances)
module tb_condlogic_it;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, ITCond, ITThen;
  logic [1:0] FlagW;
  logic [2:0] ITLen;
  logic       PCS, NextPC, RegW, MemW, NoWrite, InstrDone, ITStart;
  logic       pcw_a, rw_a, mw_a, act_a, pcw_b, rw_b, mw_b, act_b;
  logic [3:0] fl_a, fl_b;
  logic [1:0] slot_a, slot_b;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  condlogic_it #(.MAX_IT(4), .FLAG_WB_DELAY(1'b0)) dut_a (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .InstrDone(InstrDone), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITThen(ITThen),
    .PCWrite(pcw_a), .RegWrite(rw_a), .MemWrite(mw_a), .Flags(fl_a), .ITActive(act_a), .ITSlot(slot_a)
  );
  condlogic_it #(.MAX_IT(2), .FLAG_WB_DELAY(1'b1)) dut_b (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .InstrDone(InstrDone), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITThen(ITThen),
    .PCWrite(pcw_b), .RegWrite(rw_b), .MemWrite(mw_b), .Flags(fl_b), .ITActive(act_b), .ITSlot(slot_b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic got(input logic [7:0] obs);
    string t;
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s got=%0h want=%0h", t, obs, e);
      end
    end
  endtask

  task automatic idle_inputs;
    Cond = 4'b1110; ALUFlags = 4'b0; FlagW = 2'b0; PCS = 1'b0; NextPC = 1'b0;
    RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; InstrDone = 1'b0; ITStart = 1'b0;
    ITCond = 4'b0; ITLen = 3'd0; ITThen = 4'b0;
  endtask

  // decode cycle then a writeback cycle carrying RegW and InstrDone
  task automatic it_instr(input string tag, input logic rw, input logic [1:0] s);
    RegW = 1'b0; InstrDone = 1'b0;
    tick();
    RegW = 1'b1; InstrDone = 1'b1;
    want({tag, "_regwrite"}, {7'b0, rw});
    want({tag, "_slot"}, {6'b0, s});
    #2;
    got({7'b0, rw_a});
    got({6'b0, slot_a});
    tick();
    RegW = 1'b0; InstrDone = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0; RegW = 1'b1; MemW = 1'b1;
    want("rst_regwrite", 8'd0); want("rst_memwrite", 8'd0); want("rst_pcwrite", 8'd0);
    want("rst_flags", 8'd0); want("rst_itactive", 8'd0);
    #2;
    got({7'b0, rw_a}); got({7'b0, mw_a}); got({7'b0, pcw_a}); got({4'b0, fl_a}); got({7'b0, act_a});
    tick();
    NextPC = 1'b1;
    want("rst_pcwrite_nextpc", 8'd1);
    #2; got({7'b0, pcw_a});
    NextPC = 1'b0; MemW = 1'b0; reset = 1'b1;
    want("condexq_before_edge", 8'd0);
    #2; got({7'b0, rw_a});
    tick();
    want("condexq_al", 8'd1);
    #2; got({7'b0, rw_a});
    Cond = 4'b1111;
    tick();
    want("condexq_nv", 8'd0);
    #2; got({7'b0, rw_a});
    RegW = 1'b0; Cond = 4'b1110;

    FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    FlagW = 2'b00; ALUFlags = 4'b1000;
    want("flags_immediate", 8'h04); want("flags_delayed_first_edge", 8'h00);
    #2; got({4'b0, fl_a}); got({4'b0, fl_b});
    tick();
    want("flags_delayed_second_edge", 8'h08); want("flags_immediate_hold", 8'h04);
    #2; got({4'b0, fl_b}); got({4'b0, fl_a});
    FlagW = 2'b01; ALUFlags = 4'b1111;
    tick();
    want("flags_cv_only", 8'h07);
    #2; got({4'b0, fl_a});
    FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    FlagW = 2'b00;
    want("flags_restore", 8'h04);
    #2; got({4'b0, fl_a});
    tick();
    want("flags_delayed_restore", 8'h04);
    #2; got({4'b0, fl_b});
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick();
    want("flags_cond_fail_hold", 8'h04);
    #2; got({4'b0, fl_a});
    FlagW = 2'b00;

    RegW = 1'b1; Cond = 4'b0001;
    tick();
    want("ne_with_z_regwrite", 8'd0);
    #2; got({7'b0, rw_a});
    Cond = 4'b0000;
    tick();
    NoWrite = 1'b1; MemW = 1'b1; PCS = 1'b1;
    want("eq_nowrite_regwrite", 8'd0); want("eq_memwrite", 8'd1); want("eq_branch_pcwrite", 8'd1);
    #2; got({7'b0, rw_a}); got({7'b0, mw_a}); got({7'b0, pcw_a});
    NoWrite = 1'b0;
    want("eq_regwrite", 8'd1);
    #1; got({7'b0, rw_a});
    Cond = 4'b0001; NoWrite = 1'b1;
    tick();
    want("ne_nowrite_regwrite", 8'd0); want("ne_memwrite", 8'd0); want("ne_branch_pcwrite", 8'd0);
    #2; got({7'b0, rw_a}); got({7'b0, mw_a}); got({7'b0, pcw_a});
    idle_inputs();

    ITStart = 1'b1; ITCond = 4'b0000; ITLen = 3'd3; ITThen = 4'b0101; InstrDone = 1'b1;
    tick();
    ITStart = 1'b0; InstrDone = 1'b0; Cond = 4'b1111;
    want("it_start_active", 8'd1); want("it_start_slot", 8'd0);
    #2; got({7'b0, act_a}); got({6'b0, slot_a});
    it_instr("it_slot0", 1'b1, 2'd0);
    it_instr("it_slot1", 1'b0, 2'd1);
    it_instr("it_slot2", 1'b1, 2'd2);
    want("it_end_active", 8'd0);
    #2; got({7'b0, act_a});
    Cond = 4'b1110;
    it_instr("post_it", 1'b1, 2'd0);

    reset = 1'b0; #1; reset = 1'b1;
    idle_inputs();
    ITStart = 1'b1; ITCond = 4'b1110; ITLen = 3'd4; ITThen = 4'b0000;
    tick();
    ITStart = 1'b0;
    want("len4_active_a", 8'd1); want("len4_active_b", 8'd1);
    #2; got({7'b0, act_a}); got({7'b0, act_b});
    InstrDone = 1'b1;
    tick(); tick();
    InstrDone = 1'b0;
    want("clamp_b_idle", 8'd0); want("noclamp_a_active", 8'd1); want("noclamp_a_slot", 8'd2);
    #2; got({7'b0, act_b}); got({7'b0, act_a}); got({6'b0, slot_a});
    ITStart = 1'b1; ITCond = 4'b0000; ITThen = 4'b1111; ITLen = 3'd1;
    tick();
    ITStart = 1'b0;
    want("nested_slot", 8'd2); want("nested_active", 8'd1);
    #2; got({6'b0, slot_a}); got({7'b0, act_a});
    tick();
    RegW = 1'b1;
    want("nested_cond_kept", 8'd1);
    #2; got({7'b0, rw_a});
    RegW = 1'b0; InstrDone = 1'b1;
    tick(); tick();
    InstrDone = 1'b0;
    want("len4_end", 8'd0);
    #2; got({7'b0, act_a});

    ITStart = 1'b1; ITLen = 3'd0;
    tick();
    ITStart = 1'b0;
    want("len0_ignored_a", 8'd0); want("len0_ignored_b", 8'd0);
    #2; got({7'b0, act_a}); got({7'b0, act_b});

    ITStart = 1'b1; ITLen = 3'd4; ITCond = 4'b1110; ITThen = 4'b1111;
    tick();
    ITStart = 1'b0;
    tick();
    PCS = 1'b1; InstrDone = 1'b1;
    want("branch_pcwrite", 8'd1); want("branch_slot", 8'd0);
    #2; got({7'b0, pcw_a}); got({6'b0, slot_a});
    tick();
    PCS = 1'b0; InstrDone = 1'b0;
    want("branch_abort", 8'd0);
    #2; got({7'b0, act_a});

    ITStart = 1'b1;
    tick();
    ITStart = 1'b0; InstrDone = 1'b1;
    tick();
    InstrDone = 1'b0;
    want("pre_async_active", 8'd1); want("pre_async_slot", 8'd1);
    #2; got({7'b0, act_a}); got({6'b0, slot_a});
    reset = 1'b0;
    #1;
    want("async_active", 8'd0); want("async_slot", 8'd0); want("async_active_b", 8'd0);
    got({7'b0, act_a}); got({6'b0, slot_a}); got({7'b0, act_b});
    reset = 1'b1;
    tick();
    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
